// File: rtl/mult_arb_pkg.sv
// Shared types and default sizing for the
// round-robin multiplier front end.
package mult_arb_pkg;

  localparam int N_REQ_DEF   = 4;
  localparam int WIDTH_DEF   = 16;
  localparam int TIMEOUT_DEF = 40;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the
// search starts just after last_grant.
module rr_arbiter
  import mult_arb_pkg::*;
#(
  parameter int N = N_REQ_DEF,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic [IW-1:0] idx;

  // Walk from lowest to highest priority;
  // the last hit is the winner.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    idx       = '0;
    for (int i = N; i >= 1; i--) begin
      idx = IW'((int'(last_grant) + i) % N);
      if (req[idx]) begin
        grant     = N'(1) << idx;
        grant_idx = idx;
      end
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// Shares one multi-cycle multiplier among
// N_REQ requesters with a watchdog.
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int N_REQ   = N_REQ_DEF,
  parameter int WIDTH   = WIDTH_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  localparam int IDW    = idx_w(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   rsp_valid,
  output logic [IDW-1:0]         rsp_id,
  output logic [2*WIDTH-1:0]     rsp_product,
  input  logic                   rsp_ready,
  output logic                   mul_start,
  output logic [WIDTH-1:0]       mul_a,
  output logic [WIDTH-1:0]       mul_b,
  input  logic                   mul_done,
  input  logic [2*WIDTH-1:0]     mul_product,
  output logic                   timeout_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_e             state_q, state_d;
  logic [IDW-1:0]     last_q, last_d;
  logic [IDW-1:0]     id_q, id_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               terr_q, terr_d;

  logic [N_REQ-1:0]   grant;
  logic [IDW-1:0]     gidx;

  rr_arbiter #(.N(N_REQ)) u_rr (
    .req        (req_valid),
    .last_grant (last_q),
    .grant      (grant),
    .grant_idx  (gidx)
  );

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    id_d      = id_q;
    a_d       = a_q;
    b_d       = b_q;
    prod_d    = prod_q;
    cnt_d     = cnt_q;
    terr_d    = terr_q;
    req_ready = '0;
    mul_start = 1'b0;
    rsp_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = grant;
        if (|grant) begin
          id_d    = gidx;
          a_d     = req_a[gidx*WIDTH +: WIDTH];
          b_d     = req_b[gidx*WIDTH +: WIDTH];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        mul_start = 1'b1;
        cnt_d     = '0;
        state_d   = WAIT;
      end
      WAIT: begin
        // done beats the watchdog on a tie
        if (mul_done) begin
          prod_d  = mul_product;
          state_d = RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          prod_d  = '0;
          terr_d  = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          last_d  = id_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      req_ready = '0;
      mul_start = 1'b0;
      rsp_valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= IDW'(N_REQ - 1);
      id_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      a_q     <= a_d;
      b_q     <= b_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
      terr_q  <= terr_d;
    end
  end

  assign rsp_id      = id_q;
  assign rsp_product = prod_q;
  assign mul_a       = a_q;
  assign mul_b       = b_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Scoreboard bench for mult_arbiter with
// a behavioural multiplier stub.
module tb_mult_arbiter;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int TO = 40;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_a, req_b;
  logic [N-1:0]   req_ready;
  logic           rsp_valid;
  logic [IW-1:0]  rsp_id;
  logic [2*W-1:0] rsp_product;
  logic           rsp_ready;
  logic           mul_start;
  logic [W-1:0]   mul_a, mul_b;
  logic           mul_done;
  logic [2*W-1:0] mul_product;
  logic           timeout_err;

  always #5 clk = ~clk;

  mult_arbiter #(
    .N_REQ   (N),
    .WIDTH   (W),
    .TIMEOUT (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_id      (rsp_id),
    .rsp_product (rsp_product),
    .rsp_ready   (rsp_ready),
    .mul_start   (mul_start),
    .mul_a       (mul_a),
    .mul_b       (mul_b),
    .mul_done    (mul_done),
    .mul_product (mul_product),
    .timeout_err (timeout_err)
  );

  typedef struct {
    int             id;
    logic [2*W-1:0] prod;
    bit             tmo;
    int             hs;
    int             lat;
  } exp_t;

  exp_t           sbq[$];
  int             grant_log[$];
  int             tests = 0;
  int             fails = 0;
  int             cyc = 0;
  int             n_hs = 0;
  int             n_start = 0;
  int             last_g = N - 1;
  bit             terr_m = 1'b0;
  logic [N-1:0]   pend = '0;
  logic [W-1:0]   opa[N];
  logic [W-1:0]   opb[N];
  bit             hold_all = 1'b0;
  bit             force_tmo = 1'b0;
  bit             rnd = 1'b0;
  int             fixed_lat = 3;
  int             stall = 0;
  int             stub_lat = 1;
  bit             stub_tmo = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int rr_pick(
    input logic [N-1:0] p, input int lg);
    for (int i = 1; i <= N; i++)
      if (p[(lg + i) % N]) return (lg + i) % N;
    return -1;
  endfunction

  function automatic logic [W-1:0] rnd_op();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      default: return W'($urandom);
    endcase
  endfunction

  // requester driver and request-side model
  initial begin
    logic [N-1:0] exp_rdy, hs_m;
    int w, dk;
    exp_t e;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      for (int k = 0; k < N; k++) begin
        req_valid[k]     = pend[k];
        req_a[k*W +: W]  = opa[k];
        req_b[k*W +: W]  = opb[k];
      end
      if (stall > 0 && rsp_valid) begin
        rsp_ready = 1'b0;
        stall--;
      end else if (rnd) begin
        rsp_ready = ($urandom_range(0, 9) < 7);
      end else begin
        rsp_ready = 1'b1;
      end
      #1;
      w = rr_pick(req_valid, last_g);
      exp_rdy = '0;
      if (!rst && sbq.size() == 0 && w >= 0)
        exp_rdy[w] = 1'b1;
      tests++;
      if (req_ready !== exp_rdy) begin
        fails++;
        $display("FAIL req_ready: got %b want %b",
                 req_ready, exp_rdy);
      end
      hs_m = req_ready & req_valid;
      if (!rst && hs_m != '0 && w >= 0) begin
        dk = 0;
        for (int i = N - 1; i >= 0; i--)
          if (hs_m[i]) dk = i;
        grant_log.push_back(dk);
        e.id  = w;
        e.tmo = force_tmo ||
                (rnd && $urandom_range(0, 19) == 0);
        e.prod = e.tmo ? '0 :
                 (2*W)'(opa[w]) * (2*W)'(opb[w]);
        e.lat = e.tmo ? TO :
                (rnd ? int'($urandom_range(1, 6))
                     : fixed_lat);
        e.hs  = cyc;
        stub_tmo = e.tmo;
        stub_lat = e.lat;
        sbq.push_back(e);
        n_hs++;
        if (!hold_all) pend[dk] = 1'b0;
      end
    end
  end

  // multiplier stub: product taken from the
  // operand bus at completion time
  initial begin
    int rem;
    rem = 0;
    mul_done = 1'b0;
    mul_product = '0;
    forever begin
      @(negedge clk);
      #1;
      mul_done = 1'b0;
      if (rst) begin
        rem = 0;
      end else if (mul_start) begin
        rem = stub_tmo ? 0 : stub_lat;
        if (rnd && $urandom_range(0, 3) == 0) begin
          mul_done    = 1'b1;
          mul_product = '1;
        end
      end else if (rem > 0) begin
        rem--;
        if (rem == 0) begin
          mul_done    = 1'b1;
          mul_product = (2*W)'(mul_a) * (2*W)'(mul_b);
        end
      end else if (rnd && sbq.size() == 0 &&
                   $urandom_range(0, 4) == 0) begin
        mul_done    = 1'b1;
        mul_product = '1;
      end
    end
  end

  // response monitor
  initial begin
    exp_t e;
    bit in_resp;
    logic [IW-1:0]  h_id;
    logic [2*W-1:0] h_prod;
    int lat;
    in_resp = 1'b0;
    h_id = '0;
    h_prod = '0;
    forever begin
      @(negedge clk);
      #3;
      if (rst) begin
        sbq.delete();
        last_g  = N - 1;
        terr_m  = 1'b0;
        n_start = 0;
        in_resp = 1'b0;
      end else begin
        if (mul_start) n_start++;
        if (rsp_valid && sbq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL rsp_unexpected: id=%0d prod=%h",
                   rsp_id, rsp_product);
        end else if (rsp_valid) begin
          e = sbq[0];
          if (!in_resp) begin
            if (e.tmo) terr_m = 1'b1;
            lat = cyc - e.hs;
            tests++;
            if (rsp_id !== IW'(e.id) ||
                rsp_product !== e.prod ||
                timeout_err !== terr_m ||
                lat != e.lat + 2 || n_start != 1) begin
              fails++;
              $display({"FAIL rsp: got id=%0d prod=%h ",
                        "terr=%b lat=%0d starts=%0d; want ",
                        "id=%0d prod=%h terr=%b lat=%0d ",
                        "starts=1"},
                       rsp_id, rsp_product, timeout_err,
                       lat, n_start, e.id, e.prod, terr_m,
                       e.lat + 2);
            end
            in_resp = 1'b1;
            h_id    = rsp_id;
            h_prod  = rsp_product;
          end else begin
            tests++;
            if (rsp_id !== h_id || rsp_product !== h_prod ||
                mul_start !== 1'b0 || req_ready !== '0) begin
              fails++;
              $display({"FAIL resp_hold: got id=%0d ",
                        "prod=%h start=%b rdy=%b; want ",
                        "id=%0d prod=%h start=0 rdy=0"},
                       rsp_id, rsp_product, mul_start,
                       req_ready, h_id, h_prod);
            end
          end
          if (rsp_ready) begin
            void'(sbq.pop_front());
            last_g  = e.id;
            in_resp = 1'b0;
            n_start = 0;
          end
        end
      end
    end
  end

  task automatic check_zero(input string tag);
    tests++;
    if ({req_ready, rsp_valid, rsp_id, rsp_product,
         mul_start, mul_a, mul_b, timeout_err} !== '0) begin
      fails++;
      $display({"FAIL %s: got rdy=%b v=%b id=%0d p=%h ",
                "st=%b a=%h b=%h terr=%b; want all 0"},
               tag, req_ready, rsp_valid, rsp_id,
               rsp_product, mul_start, mul_a, mul_b,
               timeout_err);
    end
  endtask

  task automatic wait_idle(input string tag);
    int i;
    i = 0;
    while ((sbq.size() != 0 || pend != '0) && i < 3000) begin
      @(negedge clk);
      i++;
    end
    tests++;
    if (sbq.size() != 0 || pend != '0) begin
      fails++;
      $display("FAIL %s_drain: got open=%0d pend=%b want 0",
               tag, sbq.size(), pend);
    end
  endtask

  task automatic issue(input int k,
                       input logic [W-1:0] a,
                       input logic [W-1:0] b);
    opa[k]  = a;
    opb[k]  = b;
    pend[k] = 1'b1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1);
  end

  initial begin
    int exp_o[5];
    int got, base;
    for (int k = 0; k < N; k++) begin
      opa[k] = '0;
      opb[k] = '0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    issue(0, 16'd3, 16'd5);
    wait_idle("single");
    issue(1, 16'hFFFF, 16'hFFFF);
    wait_idle("max");
    issue(2, 16'h0000, 16'h1234);
    wait_idle("zero");

    stall = 5;
    issue(3, 16'h00AB, 16'h0CD0);
    wait_idle("backpressure");
    tests++;
    if (stall != 0) begin
      fails++;
      $display("FAIL bp_stall: got left=%0d want 0", stall);
    end

    grant_log.delete();
    hold_all = 1'b1;
    for (int k = 0; k < N; k++)
      issue(k, W'(k + 1), W'(k + 7));
    for (int i = 0; i < 2000 && grant_log.size() < 5; i++)
      @(negedge clk);
    pend = '0;
    hold_all = 1'b0;
    exp_o = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 5; i++) begin
      got = (grant_log.size() > i) ? grant_log[i] : -1;
      tests++;
      if (got != exp_o[i]) begin
        fails++;
        $display("FAIL rr_order[%0d]: got %0d want %0d",
                 i, got, exp_o[i]);
      end
    end
    wait_idle("contention");

    force_tmo = 1'b1;
    issue(1, 16'd7, 16'd9);
    @(negedge clk);
    @(negedge clk);
    force_tmo = 1'b0;
    wait_idle("timeout");
    issue(2, 16'd100, 16'd200);
    wait_idle("after_timeout");
    tests++;
    if (timeout_err !== 1'b1) begin
      fails++;
      $display("FAIL terr_sticky: got %b want 1",
               timeout_err);
    end

    fixed_lat = 20;
    issue(2, 16'd11, 16'd13);
    for (int i = 0; i < 100 && sbq.size() == 0; i++)
      @(negedge clk);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_zero("rst_midwait");
    rst = 1'b0;
    fixed_lat = 3;
    grant_log.delete();
    issue(3, 16'd21, 16'd22);
    issue(0, 16'd31, 16'd32);
    wait_idle("post_reset");
    got = (grant_log.size() > 0) ? grant_log[0] : -1;
    tests++;
    if (got != 0) begin
      fails++;
      $display("FAIL post_rst_grant: got %0d want 0", got);
    end

    rnd = 1'b1;
    base = n_hs;
    for (int c = 0; c < 8000 && n_hs < base + 60; c++) begin
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        if (!pend[k] && $urandom_range(0, 3) == 0)
          issue(k, rnd_op(), rnd_op());
        else if (pend[k] && $urandom_range(0, 29) == 0)
          pend[k] = 1'b0;
      end
    end
    wait_idle("random");
    rnd = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing one multiplier.
REQ-002 Parameter WIDTH, default 16, operand width; product width is 2*WIDTH.
REQ-003 Parameter TIMEOUT, default 40, maximum WAIT cycles before abandoning a multiply.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset: clk input 1 (rising-edge clock) and rst input 1 (synchronous active-high reset).
REQ-005 The block SHALL provide these requester ports:
- req_valid input N_REQ: per-requester operand valid.
- req_a input N_REQ*WIDTH: packed multiplicands, requester k in bits [k*WIDTH +: WIDTH].
- req_b input N_REQ*WIDTH: packed multipliers, same packing.
- req_ready output N_REQ: one-hot accept to the grant winner.
REQ-006 The block SHALL provide these response ports:
- rsp_valid output 1: result available.
- rsp_id output clog2(N_REQ): index of the served requester.
- rsp_product output 2*WIDTH: unsigned product.
- rsp_ready input 1: consumer accepts the result.
REQ-007 The block SHALL provide these multiplier-side ports:
- mul_start output 1: one-cycle start pulse to the shift-add multiplier.
- mul_a output WIDTH and mul_b output WIDTH: operands.
- mul_done input 1: multiplier completion pulse.
- mul_product input 2*WIDTH: multiplier result.
REQ-008 The block SHALL provide timeout_err output 1, a sticky flag set when a multiply times out.

Function
REQ-009 The FSM SHALL have four states, IDLE, ISSUE, WAIT and RESP, and enter IDLE on reset.
REQ-010 IDLE: when any req_valid bit is high, the block SHALL select one winner round-robin, starting at last_grant+1 modulo N_REQ.
REQ-011 IDLE: the block SHALL drive req_ready combinationally high for the winner only.
REQ-012 IDLE: on the winner's handshake the block SHALL latch its operands and index, then go to ISSUE.
REQ-013 req_ready SHALL be all-zero in every state except IDLE.
REQ-014 A requester may drop req_valid before it is granted; it SHALL lose nothing and the block SHALL impose no lock.
REQ-015 ISSUE: mul_start SHALL be high for exactly one cycle, then the FSM goes to WAIT.
REQ-016 ISSUE: the WAIT cycle counter SHALL be cleared.
REQ-017 mul_a and mul_b SHALL hold the latched operands, stable from ISSUE through the end of WAIT.
REQ-018 mul_done SHALL be ignored in the ISSUE cycle and in IDLE.
REQ-019 WAIT: on mul_done the block SHALL register mul_product into rsp_product and go to RESP.
REQ-020 WAIT: if the counter reaches TIMEOUT-1 without mul_done, the block SHALL go to RESP with rsp_product = 0 and set timeout_err.
REQ-021 When mul_done and timeout coincide in the same cycle, mul_done SHALL win and timeout_err SHALL stay unchanged.
REQ-022 RESP: rsp_valid SHALL be high, and rsp_id and rsp_product SHALL be held stable until rsp_ready is sampled high.
REQ-023 RESP: on the rsp_ready handshake the block SHALL update last_grant to the served index and return to IDLE.
REQ-024 RESP to IDLE SHALL take one cycle, so a new grant occurs no earlier than the cycle after the response handshake.
REQ-025 Latency from request handshake to rsp_valid SHALL be 1 + L + 1 cycles, where L is the multiplier's start-to-done latency.
REQ-026 The product SHALL be unsigned and 2*WIDTH wide, with no truncation.

Reset
REQ-027 On rst all outputs SHALL be 0: req_ready, rsp_valid, rsp_id, rsp_product, mul_start, mul_a, mul_b and timeout_err.
REQ-028 On rst, last_grant SHALL be N_REQ-1, so requester 0 has first priority.
REQ-029 Reset asserted in any state, including mid-WAIT, SHALL abort the operation, clear timeout_err and return the FSM to IDLE on the next edge.
REQ-030 The multiplier SHALL share the same rst, and any pending result SHALL be discarded.
REQ-031 timeout_err SHALL be cleared only by rst.

Structure
REQ-032 Package mult_arb_pkg SHALL hold the state enum (IDLE/ISSUE/WAIT/RESP) and the default constants for N_REQ, WIDTH and TIMEOUT.
REQ-033 Round-robin selection SHALL be a sub-module rr_arbiter with inputs req and last_grant, and outputs one-hot grant and grant index.
REQ-034 rr_arbiter SHALL be purely combinational.

Verification
REQ-035 Single request: req_valid=0001, a=3, b=5 -> req_ready=0001 for one cycle, one mul_start pulse, then rsp_valid with rsp_id=0 and rsp_product=15.
REQ-036 Width boundary: a=0xFFFF, b=0xFFFF -> rsp_product=0xFFFE0001; a=0, b=0x1234 -> rsp_product=0.
REQ-037 Contention: req_valid=1111 held, rsp_ready=1 -> grant order 0,1,2,3,0, with exactly one req_ready bit high per grant.
REQ-038 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_id and rsp_product stable; req_ready=0000; no mul_start.
REQ-039 Timeout: mul_done held 0 -> after 40 WAIT cycles rsp_valid=1, rsp_product=0, timeout_err=1; timeout_err stays 1 across the next normal transaction.
REQ-040 Reset mid-WAIT: assert rst for 1 cycle -> next cycle IDLE, all outputs 0, timeout_err=0; a following request from requester 0 is granted first.
